// File: rtl/pam4_prbs_checker.sv
// PAM4 level demapper followed by a self-synchronizing PRBS-7 checker with
// a lock state machine and saturating bit/error counters for BER measurement.
module pam4_prbs_checker #(
  parameter int unsigned SIGNAL_RESOLUTION = 8,
  parameter int unsigned SYMBOL_SEPERATION = 56,
  parameter int unsigned LOCK_COUNT        = 16,
  parameter int unsigned WINDOW            = 64,
  parameter int unsigned UNLOCK_ERRS       = 8,
  parameter int unsigned CNT_WIDTH         = 32
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic signed [SIGNAL_RESOLUTION-1:0] sym_in,
  input  logic                                sym_in_valid,
  input  logic                                clear_counters,
  output logic [1:0]                          bits_out,
  output logic                                bits_out_valid,
  output logic                                sym_err,
  output logic                                locked,
  output logic [CNT_WIDTH-1:0]                bit_count,
  output logic [CNT_WIDTH-1:0]                err_count
);

  localparam int unsigned SR       = SIGNAL_RESOLUTION;
  localparam int unsigned STREAK_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned WIN_W    = $clog2(WINDOW + 1);
  localparam int unsigned EWIN_W   = $clog2(UNLOCK_ERRS + 1);

  localparam logic signed [SR-1:0] THR_POS = SR'(SYMBOL_SEPERATION);
  localparam logic signed [SR-1:0] THR_NEG = -THR_POS;

  typedef enum logic {
    ST_SEEK   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [6:0]            r_hist;
  logic [2:0]            r_fill;
  logic [STREAK_W-1:0]   r_streak, w_streak_nxt;
  logic [WIN_W-1:0]      r_win, w_win_nxt;
  logic [EWIN_W-1:0]     r_ewin, w_ewin_nxt;
  logic [1:0]            r_bits_out;
  logic                  r_bits_valid;
  logic                  r_sym_err;
  logic [CNT_WIDTH-1:0]  r_bit_cnt, r_err_cnt;

  logic [1:0]            w_bits;
  logic                  w_err1, w_err0, w_bad, w_eval;
  logic [1:0]            w_nerr;
  logic                  w_locked, w_cnt_inc;
  logic [CNT_WIDTH:0]    w_bit_sum, w_err_sum;
  logic [CNT_WIDTH-1:0]  w_bit_sat, w_err_sat;

  // Gray demap of the decided level
  always_comb begin
    w_bits = 2'b00;
    if (sym_in < THR_NEG)      w_bits = 2'b00;
    else if (sym_in[SR-1])     w_bits = 2'b01;
    else if (sym_in < THR_POS) w_bits = 2'b11;
    else                       w_bits = 2'b10;
  end

  // Both predictions come from the pre-symbol history (x^7 + x^6 + 1)
  assign w_err1    = w_bits[1] ^ (r_hist[6] ^ r_hist[5]);
  assign w_err0    = w_bits[0] ^ (r_hist[5] ^ r_hist[4]);
  assign w_bad     = w_err1 | w_err0;
  assign w_nerr    = {1'b0, w_err1} + {1'b0, w_err0};
  assign w_eval    = sym_in_valid && (r_fill == 3'd7);

  assign w_bit_sum = {1'b0, r_bit_cnt} + (CNT_WIDTH+1)'(2);
  assign w_err_sum = {1'b0, r_err_cnt} + (CNT_WIDTH+1)'(w_nerr);
  assign w_bit_sat = w_bit_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : w_bit_sum[CNT_WIDTH-1:0];
  assign w_err_sat = w_err_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : w_err_sum[CNT_WIDTH-1:0];

  // Lock FSM: state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_SEEK;
      r_streak <= '0;
      r_win    <= '0;
      r_ewin   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_streak <= w_streak_nxt;
      r_win    <= w_win_nxt;
      r_ewin   <= w_ewin_nxt;
    end
  end

  // Lock FSM: next state; unlock has priority over window wrap
  always_comb begin
    w_state_nxt  = r_state;
    w_streak_nxt = r_streak;
    w_win_nxt    = r_win;
    w_ewin_nxt   = r_ewin;
    case (r_state)
      ST_SEEK: begin
        if (w_eval) begin
          if (w_bad) begin
            w_streak_nxt = '0;
          end else if (r_streak == STREAK_W'(LOCK_COUNT - 1)) begin
            w_state_nxt  = ST_LOCKED;
            w_streak_nxt = '0;
            w_win_nxt    = '0;
            w_ewin_nxt   = '0;
          end else begin
            w_streak_nxt = r_streak + STREAK_W'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (w_eval) begin
          if (w_bad && (r_ewin == EWIN_W'(UNLOCK_ERRS - 1))) begin
            w_state_nxt  = ST_SEEK;
            w_streak_nxt = '0;
            w_win_nxt    = '0;
            w_ewin_nxt   = '0;
          end else if (r_win == WIN_W'(WINDOW - 1)) begin
            w_win_nxt  = '0;
            w_ewin_nxt = '0;
          end else begin
            w_win_nxt  = r_win + WIN_W'(1);
            w_ewin_nxt = w_bad ? r_ewin + EWIN_W'(1) : r_ewin;
          end
        end
      end
      default: w_state_nxt = ST_SEEK;
    endcase
  end

  // Lock FSM: outputs
  always_comb begin
    w_locked  = (r_state == ST_LOCKED);
    w_cnt_inc = w_locked && w_eval;
  end

  // History, fill level and demapped output
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hist       <= '0;
      r_fill       <= '0;
      r_bits_out   <= '0;
      r_bits_valid <= 1'b0;
      r_sym_err    <= 1'b0;
    end else begin
      r_bits_valid <= sym_in_valid;
      r_sym_err    <= w_eval && w_bad;
      if (sym_in_valid) begin
        r_hist     <= {r_hist[4:0], w_bits};
        r_fill     <= (r_fill >= 3'd5) ? 3'd7 : r_fill + 3'd2;
        r_bits_out <= w_bits;
      end
    end
  end

  // Saturating BER counters; clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bit_cnt <= '0;
      r_err_cnt <= '0;
    end else if (clear_counters) begin
      r_bit_cnt <= '0;
      r_err_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_bit_cnt <= w_bit_sat;
      r_err_cnt <= w_err_sat;
    end
  end

  assign bits_out       = r_bits_out;
  assign bits_out_valid = r_bits_valid;
  assign sym_err        = r_sym_err;
  assign locked         = w_locked;
  assign bit_count      = r_bit_cnt;
  assign err_count      = r_err_cnt;

endmodule

// File: tb/tb_pam4_prbs_checker.sv
// Directed bench for pam4_prbs_checker: a bit-history reference model checked
// every cycle, plus literal expectations for demap, lock, errors, saturation, reset.
module tb_pam4_prbs_checker;

  localparam int unsigned SR = 8;
  localparam int SEP      = 56;
  localparam int LOCK_N   = 16;
  localparam int WIN_N    = 64;
  localparam int UNLOCK_N = 8;
  localparam longint MAX32 = 64'h0000_0000_FFFF_FFFF;
  localparam longint MAX8  = 255;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic signed [SR-1:0] sym_in = '0;
  logic                 sym_in_valid = 1'b0;
  logic                 clear_counters = 1'b0;

  logic [1:0]  bits_out, bits_out8;
  logic        bits_out_valid, bits_out_valid8;
  logic        sym_err, sym_err8;
  logic        locked, locked8;
  logic [31:0] bit_count, err_count;
  logic [7:0]  bit_count8, err_count8;

  always #5 clk = ~clk;

  pam4_prbs_checker u_dut (
    .clk(clk), .rstn(rstn), .sym_in(sym_in), .sym_in_valid(sym_in_valid),
    .clear_counters(clear_counters), .bits_out(bits_out), .bits_out_valid(bits_out_valid),
    .sym_err(sym_err), .locked(locked), .bit_count(bit_count), .err_count(err_count)
  );

  pam4_prbs_checker #(.CNT_WIDTH(8)) u_dut8 (
    .clk(clk), .rstn(rstn), .sym_in(sym_in), .sym_in_valid(sym_in_valid),
    .clear_counters(clear_counters), .bits_out(bits_out8), .bits_out_valid(bits_out_valid8),
    .sym_err(sym_err8), .locked(locked8), .bit_count(bit_count8), .err_count(err_count8)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] demap(input int x);
    if (x < -SEP)     return 2'b00;
    else if (x < 0)   return 2'b01;
    else if (x < SEP) return 2'b11;
    else              return 2'b10;
  endfunction

  function automatic int lvl_of(input logic [1:0] b);
    case (b)
      2'b00:   return -84;
      2'b01:   return -28;
      2'b11:   return 28;
      default: return 84;
    endcase
  endfunction

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  // Reference model: received bit sequence, PRBS-7 recurrence r[i] = r[i-7] ^ r[i-6]
  bit          rx[$];
  bit          m_lock = 1'b0;
  int          m_streak = 0, m_win = 0, m_ewin = 0;
  longint      m_bc = 0, m_ec = 0, m_bc8 = 0, m_ec8 = 0;
  logic [1:0]  e_bits = 2'b00;
  bit          e_valid = 1'b0, e_err = 1'b0;

  initial begin
    logic [1:0] b;
    int n, nerr;
    bit ev;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        rx.delete();
        m_lock = 1'b0; m_streak = 0; m_win = 0; m_ewin = 0;
        m_bc = 0; m_ec = 0; m_bc8 = 0; m_ec8 = 0;
        e_bits = 2'b00; e_valid = 1'b0; e_err = 1'b0;
      end else begin
        e_valid = sym_in_valid;
        e_err   = 1'b0;
        if (sym_in_valid) begin
          b      = demap(int'(sym_in));
          e_bits = b;
          n      = rx.size();
          ev     = (n >= 7);
          nerr   = 0;
          if (ev) nerr += int'(b[1] ^ rx[n-7] ^ rx[n-6]);
          rx.push_back(b[1]);
          if (ev) nerr += int'(b[0] ^ rx[n-6] ^ rx[n-5]);
          rx.push_back(b[0]);
          while (rx.size() > 16) void'(rx.pop_front());
          if (ev) begin
            e_err = (nerr != 0);
            if (!m_lock) begin
              if (nerr == 0) begin
                m_streak++;
                if (m_streak == LOCK_N) begin
                  m_lock = 1'b1; m_streak = 0; m_win = 0; m_ewin = 0;
                end
              end else begin
                m_streak = 0;
              end
            end else begin
              m_bc  = sat(m_bc + 2, MAX32);
              m_ec  = sat(m_ec + nerr, MAX32);
              m_bc8 = sat(m_bc8 + 2, MAX8);
              m_ec8 = sat(m_ec8 + nerr, MAX8);
              if (nerr != 0) m_ewin++;
              m_win++;
              if (m_ewin == UNLOCK_N) begin
                m_lock = 1'b0; m_streak = 0; m_win = 0; m_ewin = 0;
              end else if (m_win == WIN_N) begin
                m_win = 0; m_ewin = 0;
              end
            end
          end
        end
        if (clear_counters) begin
          m_bc = 0; m_ec = 0; m_bc8 = 0; m_ec8 = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (rstn) begin
        chk("m_bits_out", longint'(bits_out), longint'(e_bits));
        chk("m_bits_valid", longint'(bits_out_valid), longint'(e_valid));
        chk("m_sym_err", longint'(sym_err), longint'(e_err));
        chk("m_locked", longint'(locked), longint'(m_lock));
        chk("m_bit_count", longint'(bit_count), m_bc);
        chk("m_err_count", longint'(err_count), m_ec);
        chk("m_locked8", longint'(locked8), longint'(m_lock));
        chk("m_bit_count8", longint'(bit_count8), m_bc8);
        chk("m_err_count8", longint'(err_count8), m_ec8);
      end
    end
  end

  logic [6:0] gen = 7'h7F;
  int         pulses = 0;
  int         demap_in  [9] = '{-84, -56, -28, -1, 0, 28, 55, 56, 84};
  logic [1:0] demap_exp [9] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10};

  task automatic send_lvl(input int lvl, input bit clr = 1'b0);
    @(negedge clk);
    sym_in         = SR'(lvl);
    sym_in_valid   = 1'b1;
    clear_counters = clr;
    @(posedge clk);
    #1;
    pulses += int'(sym_err);
  endtask

  task automatic send_prbs(input int n, input bit flip = 1'b0, input bit clr = 1'b0);
    logic [1:0] b;
    for (int i = 0; i < n; i++) begin
      b[1] = gen[6] ^ gen[5]; gen = {gen[5:0], b[1]};
      b[0] = gen[6] ^ gen[5]; gen = {gen[5:0], b[0]};
      if (flip && i == 0) b[1] = ~b[1];
      send_lvl(lvl_of(b), clr);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    sym_in_valid   = 1'b0;
    clear_counters = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    sym_in_valid   = 1'b0;
    clear_counters = 1'b0;
    rstn           = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bits"}, longint'(bits_out), 0);
    chk({tag, "_valid"}, longint'(bits_out_valid), 0);
    chk({tag, "_symerr"}, longint'(sym_err), 0);
    chk({tag, "_locked"}, longint'(locked), 0);
    chk({tag, "_bitcnt"}, longint'(bit_count), 0);
    chk({tag, "_errcnt"}, longint'(err_count), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int drop;

    // Reset state
    rstn = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("reset");
    @(negedge clk);
    rstn = 1'b1;

    // Demap thresholds, one-cycle latency
    for (int i = 0; i < 9; i++) begin
      send_lvl(demap_in[i]);
      chk("demap_bits", longint'(bits_out), longint'(demap_exp[i]));
      chk("demap_valid", longint'(bits_out_valid), 1);
    end
    idle();
    @(posedge clk); #1;
    chk("valid_deassert", longint'(bits_out_valid), 0);
    chk("bits_hold", longint'(bits_out), 2);

    // Lock acquisition: 4 fill + 16 clean symbols
    do_reset();
    gen = 7'h7F;
    send_prbs(19);
    chk("lock_before_20", longint'(locked), 0);
    send_prbs(1);
    chk("lock_at_20", longint'(locked), 1);
    send_prbs(10);
    chk("bitcnt_after_10", longint'(bit_count), 20);
    chk("errcnt_clean", longint'(err_count), 0);

    // Single flipped line bit
    pulses = 0;
    send_prbs(1, 1'b1);
    send_prbs(10);
    chk("single_err_count", longint'(err_count), 3);
    chk("single_err_locked", longint'(locked), 1);
    chk("single_err_pulses_ok", longint'(pulses >= 2 && pulses <= 3), 1);
    chk("single_bitcnt", longint'(bit_count), 42);

    // Lock loss on constant +84; 2 errored symbols already in the window
    drop = 0;
    for (int i = 0; i < 64; i++) begin
      send_lvl(84);
      if (drop == 0 && !locked) drop = i + 1;
    end
    chk("loss_unlocked", longint'(locked), 0);
    chk("loss_drop_window", longint'(drop >= 6 && drop <= 9), 1);
    for (int i = 0; i < 10; i++) send_lvl(84);
    chk("seek_bitcnt_hold", longint'(bit_count), longint'(42 + 2 * drop));

    // Saturation on the 8-bit instance, then clear with a valid symbol
    do_reset();
    gen = 7'h7F;
    send_prbs(20);
    chk("sat_relock", longint'(locked8), 1);
    send_prbs(130);
    chk("sat8_bitcnt", longint'(bit_count8), 255);
    chk("sat8_errcnt", longint'(err_count8), 0);
    chk("bitcnt32_260", longint'(bit_count), 260);
    send_prbs(1, 1'b0, 1'b1);
    chk("clear_bitcnt", longint'(bit_count), 0);
    chk("clear_errcnt", longint'(err_count), 0);
    chk("clear_bitcnt8", longint'(bit_count8), 0);
    chk("clear_errcnt8", longint'(err_count8), 0);
    chk("clear_keeps_lock", longint'(locked), 1);
    send_prbs(5);
    chk("post_clear_bitcnt", longint'(bit_count), 10);

    // Asynchronous reset between edges, then relock on the resumed stream
    @(negedge clk);
    sym_in_valid = 1'b0;
    #2 rstn = 1'b0;
    #1 chk_all_zero("async_rst");
    #1 rstn = 1'b1;
    send_prbs(19);
    chk("relock_before_20", longint'(locked), 0);
    send_prbs(1);
    chk("relock_at_20", longint'(locked), 1);
    idle();
    repeat (3) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
